fp8_adder_arbiter: RTL and testbench



---
 rtl/fp8_pkg.sv | 22 ++
 rtl/fp8_adder_arbiter_rr_arbiter.sv | 52 +++++
 rtl/fp8_adder_arbiter.sv | 134 +++++++++++++
 tb/tb_fp8_adder_arbiter.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp8_pkg.sv
// fp8_pkg: shared constants and helpers for the 8-bit minifloat format
// (1 sign, 4 exponent, 3 mantissa bits).
//
// Contents:
//   FP8_W        byte width of one operand/result
//   EXP_MSB/LSB  bit positions of the exponent field
//   MAN_W        mantissa width
//   EXP_SPECIAL  all-ones exponent, marks inf/NaN
//   fp8_is_special(byte) -> 1 when the exponent field is all ones
package fp8_pkg;

    localparam int         FP8_W       = 8;
    localparam int         EXP_MSB     = 6;
    localparam int         EXP_LSB     = 3;
    localparam int         MAN_W       = 3;
    localparam logic [3:0] EXP_SPECIAL = 4'hF;

    function automatic logic fp8_is_special(input logic [FP8_W-1:0] value);
        return value[EXP_MSB:EXP_LSB] == EXP_SPECIAL;
    endfunction

endpackage

// File: rtl/fp8_adder_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin picker.
//
// Ports:
//   eligible   in   N     requesters that may be granted this cycle
//   rr_ptr     in   ID_W  highest-priority requester index
//   grant      out  N     one-hot grant (all zero when nothing is eligible)
//   grant_idx  out  ID_W  index of the granted requester (0 when none)
//   any_grant  out  1     some requester is granted
module rr_arbiter #(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    eligible,
    input  logic [ID_W-1:0] rr_ptr,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] grant_idx,
    output logic            any_grant
);

    logic            hi_hit;
    logic            lo_hit;
    logic [ID_W-1:0] hi_idx;
    logic [ID_W-1:0] lo_idx;

    // Two candidates: the lowest eligible index at or above rr_ptr, and the
    // lowest eligible index overall. The first wins when it exists; the
    // second covers the wrap-around. Scanning downward leaves the lowest
    // matching index in each candidate.
    always_comb begin
        hi_hit = 1'b0;
        lo_hit = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                lo_hit = 1'b1;
                lo_idx = ID_W'(i);
                if (i >= int'(rr_ptr)) begin
                    hi_hit = 1'b1;
                    hi_idx = ID_W'(i);
                end
            end
        end
    end

    always_comb begin
        any_grant = lo_hit;
        grant_idx = hi_hit ? hi_idx : lo_idx;
        grant     = lo_hit ? (N'(1) << grant_idx) : '0;
    end

endmodule

// File: rtl/fp8_adder_arbiter.sv
// fp8_adder_arbiter: shares one external pipelined fp8 adder between N_REQ
// requesters. Grants round-robin, issues at most one operand pair per cycle,
// tracks the owner of every in-flight add through a tag pipeline matched to
// the adder latency and returns each sum on a registered, ID-tagged bus.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid[N]      requester i has an operand pair on req_a/req_b
//   req_a, req_b      packed operands, requester i at [8i+7:8i]
//   req_ready[N]      one-hot grant
//   add_a, add_b      operands to the adder (zero when nothing is issued)
//   add_result        adder output, ADD_LAT edges after operand capture
//   rsp_valid         one-cycle result strobe
//   rsp_id/data       owner and value of the result
//   rsp_special       result exponent is all ones (inf/NaN)
//   busy              some requester has an operation outstanding
//
// Handshake: a request transfers on the rising edge that ends a cycle with
// req_valid[i] & req_ready[i]. req_ready is combinational from req_valid and
// internal state, is never high for a requester that is not valid or already
// has an operation outstanding, and a requester must hold req_a/req_b stable
// while req_valid is high. Responses have no backpressure.
module fp8_adder_arbiter
    import fp8_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int ADD_LAT = 1,
    parameter int ID_W    = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [FP8_W*N_REQ-1:0] req_a,
    input  logic [FP8_W*N_REQ-1:0] req_b,
    output logic [N_REQ-1:0]       req_ready,
    output logic [FP8_W-1:0]       add_a,
    output logic [FP8_W-1:0]       add_b,
    input  logic [FP8_W-1:0]       add_result,
    output logic                   rsp_valid,
    output logic [ID_W-1:0]        rsp_id,
    output logic [FP8_W-1:0]       rsp_data,
    output logic                   rsp_special,
    output logic                   busy
);

    logic [N_REQ-1:0] pending;
    logic [N_REQ-1:0] pending_next;
    logic [N_REQ-1:0] eligible;
    logic [N_REQ-1:0] grant;
    logic [N_REQ-1:0] clr_mask;
    logic [ID_W-1:0]  grant_idx;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  rr_ptr_next;
    logic             any_grant;

    // Tag pipeline: stage 0 is loaded at the issue edge, the last stage is
    // valid during the cycle the matching sum sits on add_result.
    logic             tag_v  [ADD_LAT];
    logic [ID_W-1:0]  tag_id [ADD_LAT];

    logic             rsp_fire;
    logic [ID_W-1:0]  rsp_fire_id;

    assign eligible = req_valid & ~pending;

    rr_arbiter #(
        .N    (N_REQ),
        .ID_W (ID_W)
    ) u_rr_arbiter (
        .eligible  (eligible),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    assign req_ready = grant;

    always_comb begin
        add_a = '0;
        add_b = '0;
        if (any_grant) begin
            add_a = req_a[grant_idx*FP8_W +: FP8_W];
            add_b = req_b[grant_idx*FP8_W +: FP8_W];
        end
    end

    // N_REQ need not be a power of two, so wrap explicitly.
    assign rr_ptr_next = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + ID_W'(1);

    assign rsp_fire    = tag_v[ADD_LAT-1];
    assign rsp_fire_id = tag_id[ADD_LAT-1];

    // A requester cannot be granted while pending, so its clear and a new
    // set never land on the same bit in the same edge.
    assign clr_mask     = rsp_fire ? (N_REQ'(1) << rsp_fire_id) : '0;
    assign pending_next = (pending & ~clr_mask) | grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending     <= '0;
            busy        <= 1'b0;
            rr_ptr      <= '0;
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_data    <= '0;
            rsp_special <= 1'b0;
            for (int i = 0; i < ADD_LAT; i++) begin
                tag_v[i]  <= 1'b0;
                tag_id[i] <= '0;
            end
        end else begin
            pending <= pending_next;
            busy    <= |pending_next;
            if (any_grant) begin
                rr_ptr <= rr_ptr_next;
            end
            // A cycle without a grant pushes a bubble.
            tag_v[0]  <= any_grant;
            tag_id[0] <= grant_idx;
            for (int i = 1; i < ADD_LAT; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_id[i] <= tag_id[i-1];
            end
            rsp_valid <= rsp_fire;
            if (rsp_fire) begin
                rsp_id      <= rsp_fire_id;
                rsp_data    <= add_result;
                rsp_special <= fp8_is_special(add_result);
            end
        end
    end

endmodule

// File: tb/tb_fp8_adder_arbiter.sv
// tb_fp8_adder_arbiter: directed bench for fp8_adder_arbiter. Two instances
// (ADD_LAT=1 and ADD_LAT=3) each drive a bench-side pipelined fp8 adder model.
// A negedge monitor per instance pushes {id, expected sum} for every transfer
// and pops/compares on every rsp_valid, including the accept-to-response
// latency.
module tb_fp8_adder_arbiter;

    localparam int N_REQ = 4;

    logic clk;
    logic rst_n;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Instance with ADD_LAT=1
    logic [3:0]  rv1;
    logic [31:0] ra1;
    logic [31:0] rb1;
    logic [3:0]  ready1;
    logic [7:0]  add_a1;
    logic [7:0]  add_b1;
    logic [7:0]  add_res1;
    logic        rsp_v1;
    logic [1:0]  rsp_id1;
    logic [7:0]  rsp_d1;
    logic        rsp_s1;
    logic        busy1;

    // Instance with ADD_LAT=3
    logic [3:0]  rv3;
    logic [31:0] ra3;
    logic [31:0] rb3;
    logic [3:0]  ready3;
    logic [7:0]  add_a3;
    logic [7:0]  add_b3;
    logic [7:0]  add_res3;
    logic        rsp_v3;
    logic [1:0]  rsp_id3;
    logic [7:0]  rsp_d3;
    logic        rsp_s3;
    logic        busy3;

    fp8_adder_arbiter #(.N_REQ(N_REQ), .ADD_LAT(1)) dut1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (rv1),
        .req_a       (ra1),
        .req_b       (rb1),
        .req_ready   (ready1),
        .add_a       (add_a1),
        .add_b       (add_b1),
        .add_result  (add_res1),
        .rsp_valid   (rsp_v1),
        .rsp_id      (rsp_id1),
        .rsp_data    (rsp_d1),
        .rsp_special (rsp_s1),
        .busy        (busy1)
    );

    fp8_adder_arbiter #(.N_REQ(N_REQ), .ADD_LAT(3)) dut3 (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (rv3),
        .req_a       (ra3),
        .req_b       (rb3),
        .req_ready   (ready3),
        .add_a       (add_a3),
        .add_b       (add_b3),
        .add_result  (add_res3),
        .rsp_valid   (rsp_v3),
        .rsp_id      (rsp_id3),
        .rsp_data    (rsp_d3),
        .rsp_special (rsp_s3),
        .busy        (busy3)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference fp8 adder ----------------
    // Values scaled by 2^9 so every representable magnitude is an integer.
    function automatic int fp8_mag(input logic [7:0] v);
        if (v[6:3] == 4'h0) return int'(v[2:0]);
        return (8 + int'(v[2:0])) << (int'(v[6:3]) - 1);
    endfunction

    function automatic logic [7:0] fp8_add(input logic [7:0] a, input logic [7:0] b);
        int   sa;
        int   sb;
        int   s;
        int   m;
        int   p;
        int   e;
        logic sg;
        if (a[6:3] == 4'hF) return {a[7], 7'h78};
        if (b[6:3] == 4'hF) return {b[7], 7'h78};
        sa = fp8_mag(a);
        if (a[7]) sa = -sa;
        sb = fp8_mag(b);
        if (b[7]) sb = -sb;
        s  = sa + sb;
        sg = (s < 0);
        m  = sg ? -s : s;
        if (m == 0) return 8'h00;
        if (m < 8) return {sg, 4'h0, m[2:0]};
        p = 3;
        while ((m >> (p + 1)) != 0) p++;
        e = p - 2;
        if (e >= 15) return {sg, 7'h78};
        return {sg, e[3:0], 3'(m >> (p - 3))};
    endfunction

    logic [7:0] pipe1 [1];
    logic [7:0] pipe3 [3];

    always @(posedge clk) begin
        pipe1[0] <= fp8_add(add_a1, add_b1);
        pipe3[0] <= fp8_add(add_a3, add_b3);
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end

    assign add_res1 = pipe1[0];
    assign add_res3 = pipe3[2];

    // ---------------- check helper ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- scoreboards ----------------
    logic [9:0] exp_q1[$];
    int         cyc_q1[$];
    logic [9:0] exp_q3[$];
    int         cyc_q3[$];
    logic [9:0] e1;
    logic [9:0] e3;
    int         c1;
    int         c3;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q1.delete();
            cyc_q1.delete();
            exp_q3.delete();
            cyc_q3.delete();
        end else begin
            if (rsp_v1) begin
                if (exp_q1.size() == 0) begin
                    chk("rsp1_unexpected", 32'd1, 32'd0);
                end else begin
                    e1 = exp_q1.pop_front();
                    c1 = cyc_q1.pop_front();
                    chk("rsp1_id", rsp_id1, e1[9:8]);
                    chk("rsp1_data", rsp_d1, e1[7:0]);
                    chk("rsp1_special", rsp_s1, e1[6:3] == 4'hF);
                    chk("rsp1_latency", cyc - c1, 2);
                end
            end
            if (rsp_v3) begin
                if (exp_q3.size() == 0) begin
                    chk("rsp3_unexpected", 32'd1, 32'd0);
                end else begin
                    e3 = exp_q3.pop_front();
                    c3 = cyc_q3.pop_front();
                    chk("rsp3_id", rsp_id3, e3[9:8]);
                    chk("rsp3_data", rsp_d3, e3[7:0]);
                    chk("rsp3_special", rsp_s3, e3[6:3] == 4'hF);
                    chk("rsp3_latency", cyc - c3, 4);
                end
            end
            for (int i = 0; i < N_REQ; i++) begin
                if (rv1[i] && ready1[i]) begin
                    exp_q1.push_back({2'(i), fp8_add(ra1[8*i +: 8], rb1[8*i +: 8])});
                    cyc_q1.push_back(cyc);
                end
                if (rv3[i] && ready3[i]) begin
                    exp_q3.push_back({2'(i), fp8_add(ra3[8*i +: 8], rb3[8*i +: 8])});
                    cyc_q3.push_back(cyc);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc_start();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic do_reset();
        mid();
        rst_n = 1'b0;
        mid();
        rst_n = 1'b1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst_n = 1'b0;
        rv1 = '0; ra1 = '0; rb1 = '0;
        rv3 = '0; ra3 = '0; rb3 = '0;
        repeat (2) @(posedge clk);
        mid();
        chk("reset_rsp_valid", {rsp_v3, rsp_v1}, 2'b00);
        chk("reset_rsp_id", {rsp_id3, rsp_id1}, 4'h0);
        chk("reset_rsp_data", {rsp_d3, rsp_d1}, 16'h0000);
        chk("reset_rsp_special", {rsp_s3, rsp_s1}, 2'b00);
        chk("reset_busy", {busy3, busy1}, 2'b00);
        chk("reset_ready", {ready3, ready1}, 8'h00);
        rst_n = 1'b1;

        // Single op on requester 0: 1.0 + 1.0 = 2.0
        cyc_start();
        rv1 = 4'b0001; ra1[7:0] = 8'h38; rb1[7:0] = 8'h38;
        mid();
        chk("t1_grant", ready1, 4'b0001);
        chk("t1_add_a", add_a1, 8'h38);
        chk("t1_add_b", add_b1, 8'h38);
        cyc_start();
        rv1 = 4'b0000;
        mid();
        chk("t1_busy_c1", busy1, 1'b1);
        chk("t1_idle_add_a", add_a1, 8'h00);
        chk("t1_rsp_v_c1", rsp_v1, 1'b0);
        cyc_start();
        mid();
        chk("t1_rsp_v_c2", rsp_v1, 1'b1);
        chk("t1_rsp_id", rsp_id1, 2'd0);
        chk("t1_rsp_data", rsp_d1, 8'h40);
        cyc_start();
        mid();
        chk("t1_rsp_v_c3", rsp_v1, 1'b0);
        chk("t1_rsp_hold", rsp_d1, 8'h40);
        chk("t1_busy_c3", busy1, 1'b0);

        // All four continuously valid: grants rotate 0,1,2,3,0,...
        do_reset();
        ra1 = {8'h30, 8'h48, 8'h40, 8'h38};
        rb1 = {8'h28, 8'hB0, 8'h3C, 8'h38};
        for (int k = 0; k < 8; k++) begin
            cyc_start();
            if (k == 0) rv1 = 4'hF;
            mid();
            chk("t2_grant", ready1, 32'd1 << (k % 4));
        end
        cyc_start();
        rv1 = 4'h0;
        repeat (3) cyc_start();
        mid();
        chk("t2_drained", exp_q1.size(), 0);
        chk("t2_busy", busy1, 1'b0);

        // Special result: 240 + 240 overflows to +inf, then 1.0 + -1.0 = 0
        cyc_start();
        rv1 = 4'b0001; ra1[7:0] = 8'h77; rb1[7:0] = 8'h77;
        mid();
        chk("t3_grant_a", ready1, 4'b0001);
        cyc_start();
        rv1 = 4'b0000;
        cyc_start();
        mid();
        chk("t3_rsp_v_a", rsp_v1, 1'b1);
        chk("t3_data_inf", rsp_d1, 8'h78);
        chk("t3_special_set", rsp_s1, 1'b1);
        cyc_start();
        mid();
        chk("t3_special_hold", rsp_s1, 1'b1);
        cyc_start();
        rv1 = 4'b0001; ra1[7:0] = 8'h38; rb1[7:0] = 8'hB8;
        mid();
        chk("t3_grant_b", ready1, 4'b0001);
        cyc_start();
        rv1 = 4'b0000;
        cyc_start();
        mid();
        chk("t3_rsp_v_b", rsp_v1, 1'b1);
        chk("t3_data_zero", rsp_d1, 8'h00);
        chk("t3_special_clear", rsp_s1, 1'b0);

        // ADD_LAT=3, requester 2 alone and held valid
        cyc_start();
        rv3 = 4'b0100; ra3[23:16] = 8'h40; rb3[23:16] = 8'h38;
        mid();
        chk("t4_grant_c0", ready3, 4'b0100);
        chk("t4_add_a", add_a3, 8'h40);
        for (int k = 1; k <= 3; k++) begin
            cyc_start();
            mid();
            chk("t4_ready_blocked", ready3, 4'b0000);
            chk("t4_rsp_v_early", rsp_v3, 1'b0);
        end
        cyc_start();
        mid();
        chk("t4_rsp_v_c4", rsp_v3, 1'b1);
        chk("t4_rsp_id", rsp_id3, 2'd2);
        chk("t4_rsp_data", rsp_d3, 8'h44);
        chk("t4_regrant_c4", ready3, 4'b0100);
        cyc_start();
        rv3 = 4'b0000;
        repeat (5) cyc_start();
        mid();
        chk("t4_drained", exp_q3.size(), 0);
        chk("t4_busy", busy3, 1'b0);

        // Reset while requester 1's op is in flight
        cyc_start();
        rv1 = 4'b0010; ra1[15:8] = 8'h40; rb1[15:8] = 8'h40;
        mid();
        chk("t5_grant", ready1, 4'b0010);
        cyc_start();
        rv1 = 4'b0000;
        rst_n = 1'b0;
        mid();
        chk("t5_busy_rst", busy1, 1'b0);
        chk("t5_ready_rst", ready1, 4'b0000);
        cyc_start();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc_start();
            mid();
            chk("t5_no_rsp", rsp_v1, 1'b0);
        end
        // rr_ptr back at 0: requester 0 beats requester 2
        cyc_start();
        rv1 = 4'b0101;
        ra1 = {8'h00, 8'h38, 8'h00, 8'h30};
        rb1 = {8'h00, 8'h30, 8'h00, 8'h38};
        mid();
        chk("t5_contention", ready1, 4'b0001);
        cyc_start();
        mid();
        chk("t5_second", ready1, 4'b0100);
        cyc_start();
        rv1 = 4'b0000;
        repeat (3) cyc_start();

        // rr_ptr now 3: requester 0 wins by wrap, then requester 2
        cyc_start();
        rv1 = 4'b0101;
        mid();
        chk("t6_wrap", ready1, 4'b0001);
        cyc_start();
        mid();
        chk("t6_next", ready1, 4'b0100);
        cyc_start();
        rv1 = 4'b0000;
        repeat (3) cyc_start();

        // rr_ptr 3 again with 0, 2, 3 valid: order 3, 0, 2
        ra1[31:24] = 8'h48; rb1[31:24] = 8'h48;
        cyc_start();
        rv1 = 4'b1101;
        mid();
        chk("t6b_first", ready1, 4'b1000);
        cyc_start();
        mid();
        chk("t6b_second", ready1, 4'b0001);
        cyc_start();
        mid();
        chk("t6b_third", ready1, 4'b0100);
        cyc_start();
        rv1 = 4'b0000;
        repeat (4) cyc_start();
        mid();
        chk("final_q1_empty", exp_q1.size(), 0);
        chk("final_q3_empty", exp_q3.size(), 0);
        chk("final_busy", {busy3, busy1}, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
